// File: rtl/rr_dispatch.sv
// Credit-based round-robin dispatcher: one upstream stream fanned out to DW targets.
// A single holding register feeds the next target with credit, scanning from a ring pointer.
module rr_dispatch #(
    parameter int DW   = 4,
    parameter int WD   = 8,
    parameter int CRED = 2
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_req,
    output logic          o_gnt,
    input  logic [WD-1:0] i_data,
    output logic [DW-1:0] o_req,
    output logic [WD-1:0] o_data,
    input  logic [DW-1:0] i_ret,
    output logic          o_err
);
    localparam int PW  = $clog2(DW);
    localparam int PW1 = PW + 1;
    localparam int CW  = $clog2(CRED + 1);
    localparam logic [CW-1:0] CRED_V   = CW'(CRED);
    localparam logic [PW-1:0] LAST_IDX = PW'(DW - 1);

    typedef enum logic {ST_EMPTY, ST_FULL} hold_state_t;

    hold_state_t   state_reg, state_next;
    logic [WD-1:0] hold_reg,  hold_next;
    logic [PW-1:0] ptr_reg,   ptr_next;
    logic [DW-1:0] req_reg,   req_next;
    logic [WD-1:0] data_reg,  data_next;
    logic          err_reg,   err_next;

    logic [DW-1:0] has_cred;
    logic [DW-1:0] ovf;
    logic [DW-1:0] sel_onehot;
    logic [DW-1:0] disp_vec;
    logic [PW-1:0] sel_idx;
    logic [PW1-1:0] cand;
    logic          sel_found;
    logic          dispatch;
    logic          transfer;

    // Per-target credit counters; a return never pushes a counter above CRED.
    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_tgt
            logic [CW-1:0] cnt_reg, cnt_next;

            assign has_cred[gi]   = (cnt_reg != '0);
            assign sel_onehot[gi] = (sel_idx == PW'(gi));
            assign ovf[gi]        = i_ret[gi] & ~disp_vec[gi] & (cnt_reg == CRED_V);

            always_comb begin
                cnt_next = cnt_reg;
                if (disp_vec[gi] && !i_ret[gi]) begin
                    cnt_next = cnt_reg - CW'(1);
                end else if (!disp_vec[gi] && i_ret[gi] && (cnt_reg != CRED_V)) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    cnt_reg <= CRED_V;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assert property (@(posedge i_clk) disable iff (!i_rstn) cnt_reg <= CRED_V);
        end
    endgenerate

    // Rotating scan from the pointer over registered credits only.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_reg;
        cand      = '0;
        for (int i = 0; i < DW; i++) begin
            cand = {1'b0, ptr_reg} + PW1'(i);
            if (cand >= PW1'(DW)) begin
                cand = cand - PW1'(DW);
            end
            if (!sel_found && has_cred[cand[PW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PW-1:0];
            end
        end
    end

    assign dispatch = (state_reg == ST_FULL) && sel_found;
    assign disp_vec = dispatch ? sel_onehot : '0;
    assign o_gnt    = (state_reg == ST_EMPTY) || dispatch;
    assign transfer = i_req && o_gnt;

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        ptr_next   = ptr_reg;
        req_next   = disp_vec;
        data_next  = data_reg;
        err_next   = err_reg | (|ovf);
        if (dispatch) begin
            data_next  = hold_reg;
            ptr_next   = (sel_idx == LAST_IDX) ? '0 : sel_idx + PW'(1);
            state_next = ST_EMPTY;
        end
        // A new item may land on the same edge the old one leaves.
        if (transfer) begin
            state_next = ST_FULL;
            hold_next  = i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= ST_EMPTY;
            hold_reg  <= '0;
            ptr_reg   <= '0;
            req_reg   <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            ptr_reg   <= ptr_next;
            req_reg   <= req_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
        end
    end

    assign o_req  = req_reg;
    assign o_data = data_reg;
    assign o_err  = err_reg;

    assert property (@(posedge i_clk) disable iff (!i_rstn) $onehot0(o_req));
    assert property (@(posedge i_clk) disable iff (!i_rstn) ptr_reg <= LAST_IDX);

endmodule
